// File: rtl/interrupt_ack_control_if.sv
// Request/acknowledge/EOI bundle between the CPU-side logic, In_Service and the 8259A ack sequencer.
// The CPU interrupt line is named int_out because `int` is a reserved word.
interface interrupt_ack_control_if;
    logic [7:0] interruptRequest;
    logic [7:0] interruptMask;
    logic [7:0] highestInServ;
    logic       inta_n;
    logic [4:0] vectorBase;
    logic       autoEOI;
    logic       ocw2Write;
    logic [7:0] ocw2;
    logic       int_out;
    logic       inServSignal;
    logic [7:0] interrupt;
    logic [7:0] clearRequest;
    logic [7:0] endOfInterrupt;
    logic [2:0] priorityRotate;
    logic [7:0] dataOut;
    logic       dataOutEnable;

    modport master (
        output interruptRequest, interruptMask, highestInServ, inta_n, vectorBase,
               autoEOI, ocw2Write, ocw2,
        input  int_out, inServSignal, interrupt, clearRequest, endOfInterrupt,
               priorityRotate, dataOut, dataOutEnable
    );

    modport slave (
        input  interruptRequest, interruptMask, highestInServ, inta_n, vectorBase,
               autoEOI, ocw2Write, ocw2,
        output int_out, inServSignal, interrupt, clearRequest, endOfInterrupt,
               priorityRotate, dataOut, dataOutEnable
    );
endinterface

// File: rtl/interrupt_ack_control.sv
// 8259A acknowledge/EOI sequencer: rotating-priority selection, INT generation,
// two-pulse INTA handling with timeout, vector drive and OCW2 EOI/rotate decode.
module interrupt_ack_control #(
    parameter logic [2:0]  DEFAULT_ROTATE = 3'd7,
    parameter int unsigned ACK_TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    interrupt_ack_control_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACK1 = 2'd1, S_ACK2 = 2'd2} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    function automatic logic [2:0] f_index(input logic [7:0] onehot);
        f_index = 3'd0;
        for (int i = 0; i < 8; i++) begin
            f_index = onehot[i] ? 3'(i) : f_index;
        end
    endfunction

    function automatic logic [2:0] f_rank(input logic [2:0] idx, input logic [2:0] rot);
        f_rank = idx - rot - 3'd1;
    endfunction

    // Scan from lowest priority upward so the last hit is the highest priority.
    function automatic logic [7:0] f_candidate(input logic [7:0] pend, input logic [2:0] rot);
        logic [2:0] idx;
        f_candidate = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            idx = rot + 3'd1 + 3'(k);
            f_candidate = pend[idx] ? (8'h01 << idx) : f_candidate;
        end
    endfunction

    state_t     r_state, w_state_next;
    logic       r_inta_prev, r_int, r_in_serv, r_spurious, r_rot_aeoi, r_doe;
    logic [7:0] r_interrupt, r_clear, r_ack_level, r_eoi, r_data_out, r_tmo;
    logic [2:0] r_rot;

    logic [7:0] w_cand, w_ocw_eoi;
    logic       w_fall, w_rise, w_ack_take, w_vec_load, w_aeoi_fire, w_int_next;
    logic       w_ocw_rot_load, w_rot_aeoi_next;
    logic [2:0] w_ocw_rot, w_rot_next;

    assign w_cand = f_candidate(bus.interruptRequest & ~bus.interruptMask, r_rot);
    assign w_fall = r_inta_prev & ~bus.inta_n;
    assign w_rise = ~r_inta_prev & bus.inta_n;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and acknowledge-phase strobes.
    always_comb begin
        w_state_next = r_state;
        w_ack_take   = 1'b0;
        w_vec_load   = 1'b0;
        w_aeoi_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_next = S_ACK1;
                    w_ack_take   = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACK1: begin
                if (w_fall) begin
                    w_state_next = S_ACK2;
                    w_vec_load   = 1'b1;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_ACK1;
                end
            end
            S_ACK2: begin
                if (w_rise) begin
                    w_state_next = S_IDLE;
                    w_aeoi_fire  = bus.autoEOI & ~r_spurious;
                end else begin
                    w_state_next = S_ACK2;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // OCW2 decode; D4:D3 = 00 identifies an OCW2 byte.
    always_comb begin
        w_ocw_eoi       = 8'h00;
        w_ocw_rot_load  = 1'b0;
        w_ocw_rot       = r_rot;
        w_rot_aeoi_next = r_rot_aeoi;
        if (bus.ocw2Write && (bus.ocw2[4:3] == 2'b00)) begin
            case (bus.ocw2[7:5])
                3'b001: w_ocw_eoi = bus.highestInServ;
                3'b011: w_ocw_eoi = 8'h01 << bus.ocw2[2:0];
                3'b101: begin
                    w_ocw_eoi = bus.highestInServ;
                    if (bus.highestInServ != 8'h00) begin
                        w_ocw_rot_load = 1'b1;
                        w_ocw_rot      = f_index(bus.highestInServ);
                    end else begin
                        w_ocw_rot_load = 1'b0;
                    end
                end
                3'b111: begin
                    w_ocw_eoi      = 8'h01 << bus.ocw2[2:0];
                    w_ocw_rot_load = 1'b1;
                    w_ocw_rot      = bus.ocw2[2:0];
                end
                3'b110: begin
                    w_ocw_rot_load = 1'b1;
                    w_ocw_rot      = bus.ocw2[2:0];
                end
                3'b100:  w_rot_aeoi_next = 1'b1;
                3'b000:  w_rot_aeoi_next = 1'b0;
                default: w_ocw_eoi = 8'h00;
            endcase
        end else begin
            w_ocw_eoi = 8'h00;
        end
    end

    // INT only asserts when staying idle, so it drops on the cycle ACK1 is entered.
    always_comb begin
        w_int_next = 1'b0;
        w_rot_next = r_rot;
        if ((r_state == S_IDLE) && (w_state_next == S_IDLE) && (w_cand != 8'h00)) begin
            w_int_next = (bus.highestInServ == 8'h00) ||
                         (f_rank(f_index(w_cand), r_rot) < f_rank(f_index(bus.highestInServ), r_rot));
        end else begin
            w_int_next = 1'b0;
        end
        if (w_ocw_rot_load) begin
            w_rot_next = w_ocw_rot;
        end else if (w_aeoi_fire && r_rot_aeoi) begin
            w_rot_next = f_index(r_ack_level);
        end else begin
            w_rot_next = r_rot;
        end
    end

    // Datapath registers and one-cycle output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inta_prev <= 1'b1;
            r_int       <= 1'b0;
            r_in_serv   <= 1'b0;
            r_interrupt <= 8'h00;
            r_clear     <= 8'h00;
            r_ack_level <= 8'h00;
            r_spurious  <= 1'b0;
            r_eoi       <= 8'h00;
            r_rot       <= DEFAULT_ROTATE;
            r_rot_aeoi  <= 1'b0;
            r_data_out  <= 8'h00;
            r_doe       <= 1'b0;
            r_tmo       <= 8'h00;
        end else begin
            r_inta_prev <= bus.inta_n;
            r_int       <= w_int_next;
            r_in_serv   <= w_ack_take && (w_cand != 8'h00);
            r_interrupt <= w_ack_take ? w_cand : 8'h00;
            r_clear     <= w_ack_take ? w_cand : 8'h00;
            r_ack_level <= w_ack_take ? ((w_cand != 8'h00) ? w_cand : 8'h80) : r_ack_level;
            r_spurious  <= w_ack_take ? (w_cand == 8'h00) : r_spurious;
            r_eoi       <= (w_aeoi_fire ? r_ack_level : 8'h00) | w_ocw_eoi;
            r_rot       <= w_rot_next;
            r_rot_aeoi  <= w_rot_aeoi_next;
            r_data_out  <= w_vec_load ? {bus.vectorBase, f_index(r_ack_level)} : r_data_out;
            r_doe       <= (w_state_next == S_ACK2);
            r_tmo       <= (r_state == S_ACK1) ? (r_tmo + 8'd1) : 8'h00;
        end
    end

    assign bus.int_out        = r_int;
    assign bus.inServSignal   = r_in_serv;
    assign bus.interrupt      = r_interrupt;
    assign bus.clearRequest   = r_clear;
    assign bus.endOfInterrupt = r_eoi;
    assign bus.priorityRotate = r_rot;
    assign bus.dataOut        = r_data_out;
    assign bus.dataOutEnable  = r_doe;
endmodule
